// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory bus: zero-latency grant from IDLE,
// grant locked across stalled accesses, optional stall timeout with a one-cycle error pulse.
module mem_bus_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_mem_write,
    input  logic        m0_mem_read,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_mem_write,
    input  logic        m1_mem_read,
    output logic [31:0] m1_rdata,
    output logic        m1_stall,
    output logic        m1_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_write,
    output logic        bus_mem_read,
    input  logic [31:0] bus_rdata,
    input  logic        bus_stall,
    output logic [1:0]  grant
);

    // state | meaning
    // IDLE  | no lock; grant decided combinationally from the current requests
    // OWN0  | master 0 holds the bus through a stalled access
    // OWN1  | master 1 holds the bus through a stalled access
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic req0, req1;
    logic own_vld, own_sel;
    logic abort;

    assign req0 = m0_mem_write | m0_mem_read;
    assign req1 = m1_mem_write | m1_mem_read;

    assign m0_rdata = bus_rdata;
    assign m1_rdata = bus_rdata;

    always_comb begin
        own_vld = 1'b0;
        own_sel = 1'b0;
        case (state_q)
            OWN0: begin
                own_vld = 1'b1;
                own_sel = 1'b0;
            end
            OWN1: begin
                own_vld = 1'b1;
                own_sel = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    own_vld = 1'b1;
                    own_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
                end else if (req0) begin
                    own_vld = 1'b1;
                    own_sel = 1'b0;
                end else if (req1) begin
                    own_vld = 1'b1;
                    own_sel = 1'b1;
                end
            end
        endcase
    end

    // cnt_q counts stalled cycles already spent; reaching TIMEOUT while still stalled aborts
    assign abort = (TIMEOUT != 0) && (state_q != IDLE) && bus_stall && (cnt_q == TO_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (own_vld) begin
            if (!bus_stall || abort) begin
                state_d = IDLE;
                last_d  = own_sel;
            end else if (state_q == IDLE) begin
                state_d = own_sel ? OWN1 : OWN0;
                cnt_d   = CW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        bus_addr      = '0;
        bus_wdata     = '0;
        bus_mem_write = 1'b0;
        bus_mem_read  = 1'b0;
        grant         = 2'b00;
        m0_stall      = req0;
        m1_stall      = req1;
        m0_err        = 1'b0;
        m1_err        = 1'b0;
        if (reset) begin
            m0_stall = 1'b1;
            m1_stall = 1'b1;
        end else if (own_vld) begin
            if (!own_sel) begin
                bus_addr      = m0_addr;
                bus_wdata     = m0_wdata;
                bus_mem_write = m0_mem_write & ~abort;
                bus_mem_read  = m0_mem_read & ~abort;
                grant         = 2'b01;
                m0_stall      = bus_stall & ~abort;
                m0_err        = abort;
            end else begin
                bus_addr      = m1_addr;
                bus_wdata     = m1_wdata;
                bus_mem_write = m1_mem_write & ~abort;
                bus_mem_read  = m1_mem_read & ~abort;
                grant         = 2'b10;
                m1_stall      = bus_stall & ~abort;
                m1_err        = abort;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (round-robin/TIMEOUT=4, fixed-priority/TIMEOUT=4,
// round-robin/no timeout) share stimulus; directed scenarios plus a random run against a model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        m0_wr, m0_rd, m1_wr, m1_rd, bus_stall;

    logic [31:0] o_m0_rdata [3];
    logic [31:0] o_m1_rdata [3];
    logic        o_m0_stall [3];
    logic        o_m1_stall [3];
    logic        o_m0_err   [3];
    logic        o_m1_err   [3];
    logic [31:0] o_addr     [3];
    logic [31:0] o_wdata    [3];
    logic        o_wr       [3];
    logic        o_rd       [3];
    logic [1:0]  o_grant    [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4)) u_rr (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mem_write(m0_wr), .m0_mem_read(m0_rd),
        .m0_rdata(o_m0_rdata[0]), .m0_stall(o_m0_stall[0]), .m0_err(o_m0_err[0]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mem_write(m1_wr), .m1_mem_read(m1_rd),
        .m1_rdata(o_m1_rdata[0]), .m1_stall(o_m1_stall[0]), .m1_err(o_m1_err[0]),
        .bus_addr(o_addr[0]), .bus_wdata(o_wdata[0]), .bus_mem_write(o_wr[0]), .bus_mem_read(o_rd[0]),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall), .grant(o_grant[0]));

    mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4)) u_fp (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mem_write(m0_wr), .m0_mem_read(m0_rd),
        .m0_rdata(o_m0_rdata[1]), .m0_stall(o_m0_stall[1]), .m0_err(o_m0_err[1]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mem_write(m1_wr), .m1_mem_read(m1_rd),
        .m1_rdata(o_m1_rdata[1]), .m1_stall(o_m1_stall[1]), .m1_err(o_m1_err[1]),
        .bus_addr(o_addr[1]), .bus_wdata(o_wdata[1]), .bus_mem_write(o_wr[1]), .bus_mem_read(o_rd[1]),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall), .grant(o_grant[1]));

    mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(0)) u_nt (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mem_write(m0_wr), .m0_mem_read(m0_rd),
        .m0_rdata(o_m0_rdata[2]), .m0_stall(o_m0_stall[2]), .m0_err(o_m0_err[2]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mem_write(m1_wr), .m1_mem_read(m1_rd),
        .m1_rdata(o_m1_rdata[2]), .m1_stall(o_m1_stall[2]), .m1_err(o_m1_err[2]),
        .bus_addr(o_addr[2]), .bus_wdata(o_wdata[2]), .bus_mem_write(o_wr[2]), .bus_mem_read(o_rd[2]),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall), .grant(o_grant[2]));

    // ---------------- reference model ----------------
    // owner: -1 = no lock, else the master locked in; waited = stall cycles already spent.
    int fp_cfg [3] = '{0, 1, 0};
    int to_cfg [3] = '{4, 4, 0};
    int own_m  [3] = '{-1, -1, -1};
    int last_m [3] = '{1, 1, 1};
    int wait_m [3] = '{0, 0, 0};

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic        s0;
        logic        s1;
        logic        e0;
        logic        e1;
    } obs_t;

    function automatic int pick(int k);
        bit r0 = m0_wr | m0_rd;
        bit r1 = m1_wr | m1_rd;
        if (own_m[k] >= 0) return own_m[k];
        if (r0 && r1) return (fp_cfg[k] != 0) ? 0 : 1 - last_m[k];
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit aborting(int k);
        return own_m[k] >= 0 && bus_stall && to_cfg[k] > 0 && wait_m[k] == to_cfg[k];
    endfunction

    function automatic obs_t model_out(int k);
        obs_t e = '0;
        int   cur;
        bit   ab;
        if (reset) begin
            e.s0 = 1'b1;
            e.s1 = 1'b1;
            return e;
        end
        cur  = pick(k);
        ab   = aborting(k);
        e.s0 = m0_wr | m0_rd;
        e.s1 = m1_wr | m1_rd;
        if (cur == 0) begin
            e.grant = 2'b01; e.addr = m0_addr; e.wdata = m0_wdata;
            e.wr = m0_wr & !ab; e.rd = m0_rd & !ab;
            e.s0 = bus_stall & !ab; e.e0 = ab;
        end else if (cur == 1) begin
            e.grant = 2'b10; e.addr = m1_addr; e.wdata = m1_wdata;
            e.wr = m1_wr & !ab; e.rd = m1_rd & !ab;
            e.s1 = bus_stall & !ab; e.e1 = ab;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            automatic int cur = pick(k);
            automatic bit ab  = aborting(k);
            if (reset) begin
                own_m[k]  <= -1;
                last_m[k] <= 1;
                wait_m[k] <= 0;
            end else if (cur >= 0) begin
                if (!bus_stall || ab) begin
                    own_m[k]  <= -1;
                    last_m[k] <= cur;
                    wait_m[k] <= 0;
                end else begin
                    own_m[k]  <= cur;
                    wait_m[k] <= wait_m[k] + 1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_m0(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        m0_wr = wr; m0_rd = rd; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive_m1(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        m1_wr = wr; m1_rd = rd; m1_addr = a; m1_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        bus_stall = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_m0(1, 0, 32'h1234_5678, 32'hAAAA_5555);
        drive_m1(0, 1, 32'h8765_4321, 32'h5555_AAAA);
        bus_stall = 1'b0;
        next_cycle();
        settle();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_grant[k] !== 2'b00 || o_wr[k] !== 1'b0 || o_rd[k] !== 1'b0 || o_addr[k] !== 32'h0 ||
                o_wdata[k] !== 32'h0 || o_m0_stall[k] !== 1'b1 || o_m1_stall[k] !== 1'b1 ||
                o_m0_err[k] !== 1'b0 || o_m1_err[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: grant=%b wr=%b rd=%b addr=%h wdata=%h st=%b%b err=%b%b, required grant=00 strobes=0 addr/wdata=0 st=11 err=00",
                         k, o_grant[k], o_wr[k], o_rd[k], o_addr[k], o_wdata[k], o_m0_stall[k], o_m1_stall[k], o_m0_err[k], o_m1_err[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset();
        drive_m0(0, 1, 32'h0000_0010, 32'h0);
        bus_stall = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        settle();
        n_checks++;
        if (o_grant[0] !== 2'b01 || o_m0_stall[0] !== 1'b0 || o_m0_rdata[0] !== 32'hDEAD_BEEF ||
            o_rd[0] !== 1'b1 || o_wr[0] !== 1'b0 || o_addr[0] !== 32'h10) begin
            n_err++;
            $display("FAIL zero_wait_m0: grant=%b stall=%b rdata=%h rd=%b wr=%b addr=%h, required 01 0 deadbeef 1 0 00000010",
                     o_grant[0], o_m0_stall[0], o_m0_rdata[0], o_rd[0], o_wr[0], o_addr[0]);
        end
        n_checks++;
        if (o_m1_stall[0] !== 1'b0 || o_m1_err[0] !== 1'b0 || o_m0_err[0] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_wait_m1_idle: m1_stall=%b m1_err=%b m0_err=%b, required 0 0 0",
                     o_m1_stall[0], o_m1_err[0], o_m0_err[0]);
        end
        next_cycle();
        drive_m0(0, 0, 0, 0);
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_m0(1, 0, 32'h100 + i, 32'hA000 + i);
            drive_m1(1, 0, 32'h200 + i, 32'hB000 + i);
            bus_stall = 1'b0;
            settle();
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            for (int k = 0; k < 3; k += 2) begin
                n_checks++;
                if (o_grant[k] !== want || o_wr[k] !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_order dut%0d cycle%0d: grant=%b wr=%b, required %b 1", k, i, o_grant[k], o_wr[k], want);
                end
            end
            next_cycle();
        end
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_fixed_prio();
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive_m0(1, 0, 32'h300 + i, 32'hC000 + i);
            else       drive_m0(0, 0, 0, 0);
            drive_m1(1, 0, 32'h400 + i, 32'hD000 + i);
            bus_stall = 1'b0;
            settle();
            want = (i < 4) ? 2'b01 : 2'b10;
            n_checks++;
            if (o_grant[1] !== want || o_m1_stall[1] !== (i < 4)) begin
                n_err++;
                $display("FAIL fixed_prio cycle%0d: grant=%b m1_stall=%b, required %b %b", i, o_grant[1], o_m1_stall[1], want, (i < 4));
            end
            if (i >= 4) drive_m1(1, 0, 32'h400 + i, 32'hD000 + i);
            next_cycle();
        end
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_locked_stall();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive_m1((c <= 4), 0, 32'h500, 32'h1111);
            drive_m0((c >= 2), 0, 32'h600, 32'h2222);
            bus_stall = (c <= 3);
            settle();
            for (int k = 0; k < 3; k++) begin
                logic [1:0] wg = (c <= 4) ? 2'b10 : 2'b01;
                logic       w1 = (c <= 3);
                logic       w0 = (c >= 2 && c <= 4);
                n_checks++;
                if (o_grant[k] !== wg || o_m1_stall[k] !== w1 || o_m0_stall[k] !== w0) begin
                    n_err++;
                    $display("FAIL locked_stall dut%0d cycle%0d: grant=%b m1_stall=%b m0_stall=%b, required %b %b %b",
                             k, c, o_grant[k], o_m1_stall[k], o_m0_stall[k], wg, w1, w0);
                end
            end
            next_cycle();
        end
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            drive_m0((c <= 5) ? 1'b0 : 1'b0, (c <= 5), 32'h700, 32'h0);
            drive_m1((c >= 2), 0, 32'h800, 32'h3333);
            bus_stall = 1'b1;
            settle();
            if (c <= 4) begin
                n_checks++;
                if (o_grant[0] !== 2'b01 || o_m0_stall[0] !== 1'b1 || o_m0_err[0] !== 1'b0 || o_rd[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL timeout_pre cycle%0d: grant=%b stall=%b err=%b rd=%b, required 01 1 0 1",
                             c, o_grant[0], o_m0_stall[0], o_m0_err[0], o_rd[0]);
                end
            end else if (c == 5) begin
                n_checks++;
                if (o_m0_stall[0] !== 1'b0 || o_m0_err[0] !== 1'b1 || o_rd[0] !== 1'b0 || o_wr[0] !== 1'b0 ||
                    o_m1_stall[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL timeout_abort: m0_stall=%b m0_err=%b rd=%b wr=%b m1_stall=%b, required 0 1 0 0 1",
                             o_m0_stall[0], o_m0_err[0], o_rd[0], o_wr[0], o_m1_stall[0]);
                end
                n_checks++;
                if (o_m0_err[2] !== 1'b0 || o_m0_stall[2] !== 1'b1 || o_grant[2] !== 2'b01) begin
                    n_err++;
                    $display("FAIL no_timeout_cycle5: err=%b stall=%b grant=%b, required 0 1 01",
                             o_m0_err[2], o_m0_stall[2], o_grant[2]);
                end
            end else begin
                n_checks++;
                if (o_grant[0] !== 2'b10 || o_m0_err[0] !== 1'b0 || o_m1_err[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_next_grant: grant=%b m0_err=%b m1_err=%b, required 10 0 0",
                             o_grant[0], o_m0_err[0], o_m1_err[0]);
                end
            end
            next_cycle();
        end
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        drive_m1(0, 1, 32'h900, 32'h0);
        bus_stall = 1'b1;
        next_cycle();
        reset = 1'b1;
        drive_m0(1, 0, 32'hA00, 32'h4444);
        settle();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_wr[k] !== 1'b0 || o_rd[k] !== 1'b0 || o_grant[k] !== 2'b00) begin
                n_err++;
                $display("FAIL reset_mid_lock_hold dut%0d: wr=%b rd=%b grant=%b, required 0 0 00", k, o_wr[k], o_rd[k], o_grant[k]);
            end
        end
        next_cycle();
        reset = 1'b0;
        bus_stall = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_grant[k] !== 2'b01 || o_wr[k] !== 1'b1 || o_m1_stall[k] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_mid_lock_release dut%0d: grant=%b wr=%b m1_stall=%b, required 01 1 1",
                         k, o_grant[k], o_wr[k], o_m1_stall[k]);
            end
        end
        next_cycle();
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_no_timeout();
        int bad = 0;
        do_reset();
        drive_m0(0, 1, 32'hB00, 32'h0);
        drive_m1(1, 0, 32'hC00, 32'h5555);
        bus_stall = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            settle();
            n_checks++;
            if (o_grant[2] !== 2'b01 || o_m0_err[2] !== 1'b0 || o_m0_stall[2] !== 1'b1 || o_m1_stall[2] !== 1'b1) begin
                n_err++;
                bad++;
                if (bad <= 4)
                    $display("FAIL no_timeout_hold cycle%0d: grant=%b err=%b m0_stall=%b m1_stall=%b, required 01 0 1 1",
                             c, o_grant[2], o_m0_err[2], o_m0_stall[2], o_m1_stall[2]);
            end
            next_cycle();
        end
        bus_stall = 1'b0;
        settle();
        n_checks++;
        if (o_grant[2] !== 2'b01 || o_m0_stall[2] !== 1'b0 || o_m0_err[2] !== 1'b0) begin
            n_err++;
            $display("FAIL no_timeout_complete: grant=%b stall=%b err=%b, required 01 0 0", o_grant[2], o_m0_stall[2], o_m0_err[2]);
        end
        next_cycle();
        drive_m0(0, 0, 0, 0);
        settle();
        n_checks++;
        if (o_grant[2] !== 2'b10) begin
            n_err++;
            $display("FAIL no_timeout_handover: grant=%b, required 10", o_grant[2]);
        end
        next_cycle();
        drive_m1(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int shown = 0;
        obs_t e, a;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: drive_m0(0, 0, $urandom, $urandom);
                    1: drive_m0(0, 1, $urandom, $urandom);
                    default: drive_m0(1, 0, $urandom, $urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: drive_m1(0, 0, $urandom, $urandom);
                    1: drive_m1(0, 1, $urandom, $urandom);
                    default: drive_m1(1, 0, $urandom, $urandom);
                endcase
            end
            bus_stall = ($urandom_range(0, 9) < 7);
            bus_rdata = $urandom;
            settle();
            for (int k = 0; k < 3; k++) begin
                e = model_out(k);
                a = {o_grant[k], o_addr[k], o_wdata[k], o_wr[k], o_rd[k],
                     o_m0_stall[k], o_m1_stall[k], o_m0_err[k], o_m1_err[k]};
                n_checks++;
                if (a !== e || o_m0_rdata[k] !== bus_rdata || o_m1_rdata[k] !== bus_rdata) begin
                    n_err++;
                    shown++;
                    if (shown <= 10)
                        $display("FAIL random dut%0d cycle%0d: got %h rdata=%h/%h, required %h rdata=%h",
                                 k, c, a, o_m0_rdata[k], o_m1_rdata[k], e, bus_rdata);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        bus_stall = 1'b0;
        bus_rdata = 32'h0;
        #1;
        test_reset();
        test_zero_wait();
        test_round_robin();
        test_fixed_prio();
        test_locked_stall();
        test_timeout();
        test_reset_mid_lock();
        test_no_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
